// File: rtl/seq_unrotator_pkg.sv
// Shared definitions for the sequential un-rotator: FSM state encoding and
// rotate-direction codes.
package seq_unrotator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/seq_unrotator_if.sv
// Handshake bundle of the un-rotator: upstream word/amount/direction in,
// restored word out, plus the busy status flag.
interface seq_unrotator_if #(
    parameter int WIDTH = 4,
    parameter int AMT_W = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             in_dir;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, in_amt, in_dir, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_dir, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/seq_unrotator_rot1.sv
// Single-position circular rotator; dir selects left (DIR_LEFT) or right (DIR_RIGHT).
module seq_unrotator_rot1
    import seq_unrotator_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] d,
    input  logic             dir,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        if (dir == DIR_RIGHT) begin
            q = {d[0], d[WIDTH-1:1]};
        end else begin
            q = {d[WIDTH-2:0], d[WIDTH-1]};
        end
    end

endmodule

// File: rtl/seq_unrotator.sv
// Iterative un-rotator: accepts a rotated word with its original amount and
// direction, rotates it back one bit per clock and presents the restored word.
module seq_unrotator
    import seq_unrotator_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_unrotator_if.slave bus
);

    state_t           state;
    logic [WIDTH-1:0] data_reg;
    logic [AMT_W-1:0] cnt;
    logic             dir_reg;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic [WIDTH-1:0] rot_q;

    // Restoring undoes the original rotation, so the step direction is inverted.
    seq_unrotator_rot1 #(.WIDTH(WIDTH)) u_rot1 (
        .d   (data_reg),
        .dir (~dir_reg),
        .q   (rot_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            data_reg    <= '0;
            cnt         <= '0;
            dir_reg     <= DIR_LEFT;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        data_reg   <= bus.in_data;
                        cnt        <= bus.in_amt;
                        dir_reg    <= bus.in_dir;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        // A zero amount needs no rotation at all.
                        if (bus.in_amt != '0) begin
                            state <= ST_SHIFT;
                        end else begin
                            state       <= ST_DONE;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_reg <= rot_q;
                    cnt      <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state       <= ST_DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = data_reg;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_seq_unrotator.sv
// Bench for seq_unrotator (WIDTH=4): directed cases, backpressure, reset
// mid-operation and a shuffled exhaustive round-trip sweep against a rotate model.
module tb_seq_unrotator;

    localparam int W = 4;
    localparam int A = 2;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    seq_unrotator_if #(.WIDTH(W), .AMT_W(A)) bus ();

    seq_unrotator #(.WIDTH(W), .AMT_W(A)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Forward rotation as the barrel rotator applied it: dir 0 = left, 1 = right.
    function automatic logic [W-1:0] fwd_rot(input logic [W-1:0] orig, input int amt,
                                             input logic dir);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (dir == 1'b0) r[(i + amt) % W] = orig[i];
            else             r[(i - amt + W) % W] = orig[i];
        end
        return r;
    endfunction

    // Present one word, wait for the result, hold it under backpressure, then release.
    // Edges are counted with the accepting edge as 1, so out_valid appears after edge amt+1.
    task automatic do_transfer(input string name, input logic [W-1:0] din, input int amt,
                               input logic dir, input logic [W-1:0] expect_data,
                               input int stall);
        int n;
        logic [W-1:0] held;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = din;
        bus.in_amt    = A'(amt);
        bus.in_dir    = dir;
        bus.out_ready = 1'b0;
        compared++;
        if (bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
        bus.in_amt   = A'($urandom);
        bus.in_dir   = 1'($urandom);
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            compared++;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                mismatched++;
                $display("FAIL %s in_ready/busy while shifting: got %b/%b want 0/1",
                         name, bus.in_ready, bus.busy);
            end
            @(negedge clk);
            n++;
        end
        compared++;
        if (n != amt + 1) begin
            mismatched++;
            $display("FAIL %s latency: got %0d edges want %0d", name, n, amt + 1);
        end
        compared++;
        if (bus.out_data !== expect_data) begin
            mismatched++;
            $display("FAIL %s out_data: got %b want %b", name, bus.out_data, expect_data);
        end
        held = bus.out_data;
        for (int s = 0; s < stall; s++) begin
            bus.in_valid = 1'($urandom);
            bus.in_data  = W'($urandom);
            @(negedge clk);
            compared++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.in_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL %s hold: valid=%b data=%b ready=%b want 1/%b/0",
                         name, bus.out_valid, bus.out_data, bus.in_ready, held);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        compared++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s release: valid=%b ready=%b busy=%b want 0/1/0",
                     name, bus.out_valid, bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_dir    = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 4'b0000
            || bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset: ready=%b valid=%b data=%b busy=%b want 1/0/0000/0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        do_transfer("left1", 4'b0101, 1, 1'b0, 4'b1010, 0);
        do_transfer("right3", 4'b1101, 3, 1'b1, 4'b1110, 0);
        do_transfer("amt0", 4'b1111, 0, 1'b1, 4'b1111, 0);
    endtask

    task automatic test_backpressure();
        do_transfer("stall5", 4'b0011, 2, 1'b0, 4'b1100, 5);
        do_transfer("after_stall", 4'b1000, 1, 1'b1, 4'b0001, 0);
    endtask

    task automatic test_reset_mid_shift();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b1001;
        bus.in_amt   = 2'd3;
        bus.in_dir   = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        compared++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0
            || bus.out_data !== 4'b0000) begin
            mismatched++;
            $display("FAIL mid_reset: ready=%b valid=%b busy=%b data=%b want 1/0/0/0000",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_data);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            compared++;
            if (bus.out_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL mid_reset_quiet: out_valid=%b want 0 at cycle %0d",
                         bus.out_valid, i);
            end
        end
    endtask

    task automatic test_sweep();
        int order[128];
        int j;
        int tmp;
        for (int i = 0; i < 128; i++) order[i] = i;
        for (int i = 127; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 128; i++) begin
            logic [W-1:0] orig;
            int amt;
            logic dir;
            orig = W'(order[i] % 16);
            amt  = (order[i] / 16) % 4;
            dir  = 1'(order[i] / 64);
            do_transfer("sweep", fwd_rot(orig, amt, dir), amt, dir, orig,
                        int'($urandom_range(2, 0)));
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_shift();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
